// File: rtl/rf_wb_sched.sv
// Writeback scheduler for the integer register file: round-robin ALU/LSU arbitration
// into a registered write stage, plus a busy-bit scoreboard that stalls issue on RAW/WAW.
module rf_wb_sched #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            alu_wb_valid,
  input  logic [4:0]      alu_wb_idx,
  input  logic [XLEN-1:0] alu_wb_data,
  output logic            alu_wb_ready,
  input  logic            lsu_wb_valid,
  input  logic [4:0]      lsu_wb_idx,
  input  logic [XLEN-1:0] lsu_wb_data,
  output logic            lsu_wb_ready,
  input  logic            iss_valid,
  input  logic            iss_rs1_used,
  input  logic [4:0]      iss_rs1_idx,
  input  logic            iss_rs2_used,
  input  logic [4:0]      iss_rs2_idx,
  input  logic            iss_rd_en,
  input  logic [4:0]      iss_rd_idx,
  output logic            iss_stall,
  input  logic            flush,
  output logic            wb_rd_en,
  output logic [4:0]      wb_rd_idx,
  output logic [XLEN-1:0] wb_rd_data
);

  typedef enum logic {SRC_ALU = 1'b0, SRC_LSU = 1'b1} src_e;

  src_e            last_grant_q, last_grant_d;
  logic            wb_en_q, wb_en_d;
  logic [4:0]      wb_idx_q, wb_idx_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [31:1]     busy_q, busy_d;
  logic [31:0]     busy_w;
  logic            alu_gnt, lsu_gnt, hazard, iss_fire;

  // Grants depend only on valids and the pointer, never on the write stage.
  always_comb begin
    alu_gnt = alu_wb_valid & (~lsu_wb_valid | (last_grant_q == SRC_LSU));
    lsu_gnt = lsu_wb_valid & ~alu_gnt;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    wb_en_d      = 1'b0;
    wb_idx_d     = wb_idx_q;
    wb_data_d    = wb_data_q;
    if (alu_gnt) begin
      last_grant_d = SRC_ALU;
      wb_en_d      = |alu_wb_idx;
      wb_idx_d     = alu_wb_idx;
      wb_data_d    = alu_wb_data;
    end else if (lsu_gnt) begin
      last_grant_d = SRC_LSU;
      wb_en_d      = |lsu_wb_idx;
      wb_idx_d     = lsu_wb_idx;
      wb_data_d    = lsu_wb_data;
    end
  end

  always_comb begin
    busy_w   = {busy_q, 1'b0};
    hazard   = (iss_rs1_used & busy_w[iss_rs1_idx])
             | (iss_rs2_used & busy_w[iss_rs2_idx])
             | (iss_rd_en    & busy_w[iss_rd_idx]);
    iss_fire = iss_valid & ~hazard & iss_rd_en & (iss_rd_idx != 5'd0);
  end

  // Priority per bit: flush over set over writeback clear.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 1; i < 32; i++) begin
      if (wb_en_q && (wb_idx_q == 5'(i)))
        busy_d[i] = 1'b0;
      if (iss_fire && (iss_rd_idx == 5'(i)))
        busy_d[i] = 1'b1;
      if (flush)
        busy_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_grant_q <= SRC_LSU;
      wb_en_q      <= 1'b0;
      wb_idx_q     <= '0;
      wb_data_q    <= '0;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wb_en_q      <= wb_en_d;
      wb_idx_q     <= wb_idx_d;
      wb_data_q    <= wb_data_d;
      busy_q       <= busy_d;
    end
  end

  assign alu_wb_ready = alu_gnt;
  assign lsu_wb_ready = lsu_gnt;
  assign iss_stall    = iss_valid & hazard;
  assign wb_rd_en     = wb_en_q;
  assign wb_rd_idx    = wb_idx_q;
  assign wb_rd_data   = wb_data_q;

endmodule

// File: doc/rf_wb_sched.md
# rf_wb_sched

Writeback scheduler and scoreboard for the 32x32 integer register file. It shares the register file's single write port between two writeback requesters, the ALU and the load/store unit, using round-robin arbitration and a registered write stage. It also tracks in-flight destination registers in a busy-bit scoreboard, so it can stall issue on RAW and WAW hazards. It sits between the execute/memory units and the register file's `wb_rd_en/wb_rd_idx/wb_rd_data` inputs, and feeds a stall signal back to the issue stage.

## Interface
Parameters:
- `XLEN`, 32, data width of writeback data.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rstn` in 1: synchronous, active-low reset, sampled on rising edge of `clk`.
- `alu_wb_valid` in 1: ALU has a result to write.
- `alu_wb_idx` in 5: ALU destination register.
- `alu_wb_data` in XLEN: ALU result.
- `alu_wb_ready` out 1: ALU request granted this cycle.
- `lsu_wb_valid` in 1: LSU has load data to write.
- `lsu_wb_idx` in 5: LSU destination register.
- `lsu_wb_data` in XLEN: load data.
- `lsu_wb_ready` out 1: LSU request granted this cycle.
- `iss_valid` in 1: issue stage presents an instruction.
- `iss_rs1_used` in 1: instruction reads rs1.
- `iss_rs1_idx` in 5: rs1 index.
- `iss_rs2_used` in 1: instruction reads rs2.
- `iss_rs2_idx` in 5: rs2 index.
- `iss_rd_en` in 1: instruction writes rd.
- `iss_rd_idx` in 5: rd index.
- `iss_stall` out 1: hazard; the instruction must not issue this cycle.
- `flush` in 1: pipeline flush; clears the scoreboard.
- `wb_rd_en` out 1: register file write enable.
- `wb_rd_idx` out 5: register file write index.
- `wb_rd_data` out XLEN: register file write data.

## Operation
Arbitration:
- A request is transferred when `x_wb_valid & x_wb_ready` are both high.
- Ready is combinational and depends on the valids and a 1-bit `last_grant` pointer.
- At most one ready is asserted per cycle.
- One valid only: that source is granted.
- Both valid: the source not equal to `last_grant` is granted.
- `last_grant` updates to the granted source on every grant.
- Reset value of `last_grant` = LSU, so the ALU wins the first contest.
- Requesters hold valid, idx and data stable until granted.

Write stage:
- The granted idx/data are registered into `wb_rd_idx/wb_rd_data`.
- `wb_rd_en` is registered as (grant & idx != 0).
- With no grant, `wb_rd_en` = 0 next cycle; idx/data hold their previous values.
- A granted write to x0 is consumed (ready=1) but produces no write.

Scoreboard (`busy[31:1]`; `busy[0]` is constant 0):
- Hazard conditions:
  - rs1 hazard: `iss_rs1_used & busy[rs1_idx]`.
  - rs2 hazard: `iss_rs2_used & busy[rs2_idx]`.
  - WAW hazard: `iss_rd_en & busy[rd_idx]`.
- `iss_stall = iss_valid & (any hazard)`. It is combinational.
- Set: `iss_valid & ~iss_stall & iss_rd_en & rd_idx!=0` sets `busy[rd_idx]` at the edge.
- Clear: `wb_rd_en` high clears `busy[wb_rd_idx]` at the end of that cycle.
- Set and clear on the same index in the same cycle: set wins.
- `flush` clears all busy bits at the edge and overrides any set in that cycle. Arbitration and the write stage are unaffected by flush; writebacks still drain.

## Timing
- Reset (`rstn`=0 at an edge):
  - `wb_rd_en`=0, `wb_rd_idx`=0, `wb_rd_data`=0.
  - All busy bits = 0; `last_grant` = LSU.
  - Readies and `iss_stall` follow their combinational definitions.
- Reset mid-operation discards a pending write stage and all busy state.
- Latency: a grant in cycle N gives `wb_rd_en`=1 in cycle N+1. The busy bit is clear from cycle N+2, so a dependent instruction stalls in N and N+1 and issues in N+2.
- Issue at edge N: `busy[rd]` is visible from cycle N+1; a back-to-back dependent instruction stalls.
- Throughput: one write per cycle. Under sustained contention the grants alternate ALU, LSU, ALU, ...
- No combinational path from `wb_rd_*` to readies.

## Test plan
1. Reset: hold `rstn`=0 for 2 cycles with all valids high. Expect `wb_rd_en`=0 and `iss_stall`=0. At the first active edge, expect ALU granted (`alu_wb_ready`=1, `lsu_wb_ready`=0).
2. Contention: both valid continuously with different idx (ALU x5, LSU x6). Expect grants alternating ALU/LSU and `wb_rd_idx` sequence 5,6,5,6 one cycle after each grant.
3. RAW: issue rd=x7 at cycle 0, then an instruction with rs1=x7. Expect stall until the ALU write to x7 is granted at cycle k. Expect `wb_rd_en`=1 at k+1, stall low and issue at k+2.
4. x0 handling: issue rd=x0, then an instruction reading x0. Expect no stall. An ALU request with idx 0 gets ready=1 and gives `wb_rd_en`=0 next cycle.
5. Same-cycle set/clear: x9 is being written back (`wb_rd_en`=1, idx 9) while a new instruction issues with rd=x9. Expect `busy[9]`=1 afterwards, so a follow-on reader of x9 stalls.
6. Flush: with x3 and x4 busy, pulse `flush` together with an issue to x8. Expect all busy bits 0 next cycle, and the in-flight LSU write to x3 still appearing on `wb_rd_*`.
